// File: rtl/axi_w_dw_downsizer.sv
// W-channel data-width downsizer: slices wide W beats into narrow W beats under
// control of per-burst commands (offset, size, len) queued by the AW splitter.
module axi_w_dw_downsizer #(
  parameter int SlvDataWidth = 64,
  parameter int MstDataWidth = 32,
  parameter int UserWidth    = 8,
  parameter int CmdDepth     = 4,
  localparam int SlvBytes    = SlvDataWidth / 8,
  localparam int MstBytes    = MstDataWidth / 8,
  localparam int OffW        = $clog2(SlvBytes)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [OffW-1:0]         cmd_offset_i,
  input  logic [2:0]              cmd_size_i,
  input  logic [7:0]              cmd_len_i,
  input  logic [SlvDataWidth-1:0] slv_w_data_i,
  input  logic [SlvBytes-1:0]     slv_w_strb_i,
  input  logic                    slv_w_last_i,
  input  logic [UserWidth-1:0]    slv_w_user_i,
  input  logic                    slv_w_valid_i,
  output logic                    slv_w_ready_o,
  output logic [MstDataWidth-1:0] mst_w_data_o,
  output logic [MstBytes-1:0]     mst_w_strb_o,
  output logic                    mst_w_last_o,
  output logic [UserWidth-1:0]    mst_w_user_o,
  output logic                    mst_w_valid_o,
  input  logic                    mst_w_ready_i,
  output logic                    err_o
);
  localparam int MstSzW = $clog2(MstBytes);
  localparam int Ratio  = SlvBytes / MstBytes;
  localparam int PtrW   = (CmdDepth > 1) ? $clog2(CmdDepth) : 1;
  localparam int FcntW  = $clog2(CmdDepth + 1);
  localparam logic [2:0] MaxSize = 3'(MstSzW);

  typedef struct packed {
    logic [OffW-1:0] off;
    logic [2:0]      size;
    logic [7:0]      len;
  } cmd_t;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  cmd_t            fifo_q [CmdDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FcntW-1:0] fcnt_q, fcnt_d;
  logic            full, empty, push, pop;
  cmd_t            head;

  state_e          state_q, state_d;
  logic [OffW-1:0] off_q, off_d;
  logic [2:0]      size_q, size_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [OffW:0]       step_w, off_w;
  logic [OffW-1:0]     mask, off_nxt, lane;
  logic                wrap, last, slv_rdy;
  logic [SlvBytes-1:0] strb_m;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(CmdDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Command FIFO; full is taken from the registered count so push never
  // depends on a same-cycle pop.
  assign full        = (fcnt_q == FcntW'(CmdDepth));
  assign empty       = (fcnt_q == '0);
  assign cmd_ready_o = !full;
  assign push        = cmd_valid_i && !full;
  assign head        = fifo_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= {cmd_offset_i, cmd_size_i, cmd_len_i};
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (push && !pop)      fcnt_d = fcnt_q + 1'b1;
    else if (!push && pop) fcnt_d = fcnt_q - 1'b1;
  end

  // Beat geometry: active lane, byte window of the current narrow beat and
  // the next (size-aligned) offset, wrapping modulo the wide beat.
  always_comb begin
    off_w   = {1'b0, off_q};
    step_w  = (OffW + 1)'(1) << size_q;
    mask    = OffW'(step_w - 1'b1);
    off_nxt = (off_q & ~mask) + OffW'(step_w);
    wrap    = (off_nxt == '0);
    last    = (cnt_q == '0);
    lane    = off_q >> MstSzW;
    for (int i = 0; i < SlvBytes; i++) begin
      strb_m[i] = slv_w_strb_i[i] && ((OffW + 1)'(i) >= off_w) &&
                  ((OffW + 1)'(i) < off_w + step_w);
    end
  end

  always_comb begin
    state_d       = state_q;
    off_d         = off_q;
    size_d        = size_q;
    cnt_d         = cnt_q;
    err_d         = 1'b0;
    pop           = 1'b0;
    slv_rdy       = 1'b0;
    mst_w_data_o  = '0;
    mst_w_strb_o  = '0;
    mst_w_last_o  = 1'b0;
    mst_w_user_o  = '0;
    mst_w_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          off_d   = head.off;
          cnt_d   = head.len;
          size_d  = head.size;
          state_d = BURST;
          if (head.size > MaxSize) begin
            size_d = MaxSize;
            err_d  = 1'b1;
          end
        end
      end
      BURST: begin
        for (int l = 0; l < Ratio; l++) begin
          if (lane == OffW'(l)) begin
            mst_w_data_o = slv_w_data_i[l*MstDataWidth +: MstDataWidth];
            mst_w_strb_o = strb_m[l*MstBytes +: MstBytes];
          end
        end
        mst_w_user_o  = slv_w_user_i;
        mst_w_last_o  = last;
        mst_w_valid_o = slv_w_valid_i;
        slv_rdy       = mst_w_ready_i && (wrap || last);
        if (slv_w_valid_i && mst_w_ready_i) begin
          off_d = off_nxt;
          cnt_d = cnt_q - 1'b1;
          if (last) state_d = IDLE;
          // A wide beat popped here must carry last exactly when the burst ends.
          if (slv_rdy && (last != slv_w_last_i)) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign slv_w_ready_o = slv_rdy;
  assign err_o         = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      off_q    <= '0;
      size_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_axi_w_dw_downsizer.sv
// Bench for axi_w_dw_downsizer (64->32): byte-address model builds the expected
// narrow beat stream per command; one negedge process compares every handshake.
module tb_axi_w_dw_downsizer;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o;
  logic [2:0]  cmd_offset_i, cmd_size_i;
  logic [7:0]  cmd_len_i;
  logic [63:0] slv_w_data_i;
  logic [7:0]  slv_w_strb_i;
  logic        slv_w_last_i;
  logic [7:0]  slv_w_user_i;
  logic        slv_w_valid_i, slv_w_ready_o;
  logic [31:0] mst_w_data_o;
  logic [3:0]  mst_w_strb_o;
  logic        mst_w_last_o;
  logic [7:0]  mst_w_user_o;
  logic        mst_w_valid_o, mst_w_ready_i;
  logic        err_o;

  axi_w_dw_downsizer #(
    .SlvDataWidth(64), .MstDataWidth(32), .UserWidth(8), .CmdDepth(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_offset_i(cmd_offset_i), .cmd_size_i(cmd_size_i), .cmd_len_i(cmd_len_i),
    .slv_w_data_i(slv_w_data_i), .slv_w_strb_i(slv_w_strb_i),
    .slv_w_last_i(slv_w_last_i), .slv_w_user_i(slv_w_user_i),
    .slv_w_valid_i(slv_w_valid_i), .slv_w_ready_o(slv_w_ready_o),
    .mst_w_data_o(mst_w_data_o), .mst_w_strb_o(mst_w_strb_o),
    .mst_w_last_o(mst_w_last_o), .mst_w_user_o(mst_w_user_o),
    .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data; logic [3:0] strb; logic last; logic [7:0] user; logic pop;
  } exp_t;
  typedef struct packed {
    logic [63:0] data; logic [7:0] strb; logic last; logic [7:0] user;
  } wide_t;
  typedef struct packed {
    logic [31:0] data; logic [3:0] strb; logic last; logic pop;
  } obs_t;

  exp_t  expq[$];
  wide_t wq[$];
  obs_t  obs[$];
  int    checks = 0, failures = 0;
  int    err_seen = 0, err_base = 0;
  int    g = 0;
  int    ready_mode = 1;
  exp_t  ce;

  function automatic logic [63:0] wdata(input int idx);
    logic [31:0] lo;
    lo = 32'hA000_0000 + 32'(2 * idx);
    return {lo + 32'd1, lo};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_cmd(input int off, input int size, input int len);
    bit acc = 0;
    int t = 0;
    cmd_valid_i  = 1'b1;
    cmd_offset_i = 3'(off);
    cmd_size_i   = 3'(size);
    cmd_len_i    = 8'(len);
    while (!acc && t < 500) begin
      @(negedge clk);
      if (cmd_ready_o) acc = 1;
      @(posedge clk); #1;
      t++;
    end
    cmd_valid_i = 1'b0;
    if (!acc) chk("cmd_push_timeout", 64'd0, 64'd1);
  endtask

  // Walks the narrow beat addresses: each beat starts at the size-aligned
  // successor of the previous one; crossing byte 8 starts a new wide beat.
  task automatic issue(input int off, input int size, input int len,
                       input logic [7:0] strb, input int mode);
    int s, a, an, lane, w;
    exp_t e;
    wide_t wb;
    logic [63:0] d;
    s = (size > 2) ? 2 : size;
    a = off;
    w = 0;
    for (int k = 0; k <= len; k++) begin
      d      = wdata(g + w);
      lane   = a / 4;
      e.data = d[lane*32 +: 32];
      for (int b = 0; b < 4; b++) begin
        int byt;
        byt = lane * 4 + b;
        e.strb[b] = strb[byt] && (byt >= a) && (byt < a + (1 << s));
      end
      e.last = (k == len);
      e.user = 8'(g + w);
      an     = ((a >> s) << s) + (1 << s);
      e.pop  = (an >= 8) || (k == len);
      a      = (an >= 8) ? 0 : an;
      expq.push_back(e);
      if (e.pop) w++;
    end
    for (int j = 0; j < w; j++) begin
      wb.data = wdata(g + j);
      wb.strb = strb;
      wb.user = 8'(g + j);
      wb.last = (mode == 0) ? (j == w - 1) : (mode == 2);
      wq.push_back(wb);
    end
    g += w;
    push_cmd(off, size, len);
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (expq.size() != 0 && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_remaining", 64'(expq.size()), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("wide_consumed", 64'(wq.size()), 64'd0);
  endtask

  // Wide-beat source and narrow ready generator.
  initial begin : src
    bit hs;
    forever begin
      @(negedge clk);
      hs = slv_w_valid_i && slv_w_ready_o;
      @(posedge clk); #1;
      if (hs && wq.size() > 0) void'(wq.pop_front());
      slv_w_valid_i = (wq.size() > 0);
      if (wq.size() > 0) begin
        slv_w_data_i = wq[0].data;
        slv_w_strb_i = wq[0].strb;
        slv_w_last_i = wq[0].last;
        slv_w_user_i = wq[0].user;
      end else begin
        slv_w_data_i = '0; slv_w_strb_i = '0; slv_w_last_i = 1'b0; slv_w_user_i = '0;
      end
      mst_w_ready_i = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  always @(negedge clk) begin
    if (rst_ni && mst_w_valid_o && mst_w_ready_i) begin
      obs.push_back({mst_w_data_o, mst_w_strb_o, mst_w_last_o, slv_w_ready_o});
      if (expq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_beat actual=%h required=none", mst_w_data_o);
      end else begin
        ce = expq.pop_front();
        checks++;
        if ({mst_w_data_o, mst_w_strb_o, mst_w_last_o, mst_w_user_o} !==
            {ce.data, ce.strb, ce.last, ce.user}) begin
          failures++;
          $display("FAIL narrow_beat actual=%h/%h/%b/%h required=%h/%h/%b/%h",
                   mst_w_data_o, mst_w_strb_o, mst_w_last_o, mst_w_user_o,
                   ce.data, ce.strb, ce.last, ce.user);
        end
        checks++;
        if (slv_w_ready_o !== ce.pop) begin
          failures++;
          $display("FAIL wide_pop actual=%b required=%b", slv_w_ready_o, ce.pop);
        end
      end
    end
    if (rst_ni && err_o) err_seen++;
  end

  initial begin
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_offset_i = '0; cmd_size_i = '0; cmd_len_i = '0;
    slv_w_data_i = '0; slv_w_strb_i = '0; slv_w_last_i = 1'b0; slv_w_user_i = '0;
    slv_w_valid_i = 1'b0; mst_w_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {mst_w_valid_o, slv_w_ready_o, mst_w_last_o, err_o,
                          mst_w_data_o, mst_w_strb_o, mst_w_user_o}, 64'd0);
    chk("reset_cmd_ready", 64'(cmd_ready_o), 64'd1);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Aligned full-width burst over two wide beats.
    obs.delete(); err_base = err_seen;
    issue(0, 2, 3, 8'hFF, 0);
    drain(100);
    chk("t1_count", 64'(obs.size()), 64'd4);
    chk("t1_data0", 64'(obs[0].data), 64'hA000_0000);
    chk("t1_data1", 64'(obs[1].data), 64'hA000_0001);
    chk("t1_data2", 64'(obs[2].data), 64'hA000_0002);
    chk("t1_data3", 64'(obs[3].data), 64'hA000_0003);
    chk("t1_last", {obs[0].last, obs[1].last, obs[2].last, obs[3].last}, 64'b0001);
    chk("t1_pop", {obs[0].pop, obs[1].pop, obs[2].pop, obs[3].pop}, 64'b0101);
    chk("t1_err", 64'(err_seen - err_base), 64'd0);

    // Single beat starting in the upper lane.
    obs.delete(); err_base = err_seen;
    issue(4, 2, 0, 8'hFF, 0);
    drain(100);
    chk("t2_beat", {obs[0].data, obs[0].strb, obs[0].last, obs[0].pop},
        {32'hA000_0005, 4'hF, 1'b1, 1'b1});
    chk("t2_err", 64'(err_seen - err_base), 64'd0);

    // Unaligned byte-sized beats inside lane 0.
    obs.delete(); err_base = err_seen;
    issue(1, 0, 2, 8'hFF, 0);
    drain(100);
    chk("t3_strb", {obs[0].strb, obs[1].strb, obs[2].strb}, {4'h2, 4'h4, 4'h8});
    chk("t3_data", 64'(obs[2].data), 64'hA000_0006);
    chk("t3_pop", {obs[0].pop, obs[1].pop, obs[2].pop}, 64'b001);

    // Fill the command FIFO behind a stalled burst, then drain with random stalls.
    err_base = err_seen;
    ready_mode = 0;
    issue(0, 2, 3, 8'hFF, 0);
    issue(2, 1, 5, 8'hA5, 0);
    issue(0, 0, 7, 8'hFF, 0);
    issue(4, 2, 1, 8'hFF, 0);
    issue(3, 0, 4, 8'h5A, 0);
    @(negedge clk);
    chk("fifo_full_ready", 64'(cmd_ready_o), 64'd0);
    chk("stall_no_pop", 64'(slv_w_ready_o), 64'd0);
    @(posedge clk); #1;
    ready_mode = 2;
    issue(0, 2, 5, 8'hFF, 0);
    drain(3000);
    ready_mode = 1;
    chk("t4_err", 64'(err_seen - err_base), 64'd0);

    // Protocol errors.
    err_base = err_seen;
    issue(0, 2, 1, 8'hFF, 1);
    drain(100);
    chk("err_missing_last", 64'(err_seen - err_base), 64'd1);
    err_base = err_seen;
    issue(0, 2, 3, 8'hFF, 0);
    drain(100);
    chk("err_clean_after", 64'(err_seen - err_base), 64'd0);
    err_base = err_seen;
    issue(0, 3, 1, 8'hFF, 0);
    drain(100);
    chk("err_oversize", 64'(err_seen - err_base), 64'd1);
    err_base = err_seen;
    issue(0, 2, 3, 8'hFF, 2);
    drain(100);
    chk("err_early_last", 64'(err_seen - err_base), 64'd1);

    // Asynchronous reset in the middle of a burst with a command queued.
    issue(0, 0, 7, 8'hFF, 0);
    issue(0, 2, 1, 8'hFF, 0);
    begin
      bit seen = 0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        if (mst_w_valid_o) seen = 1;
      end
      chk("rst_burst_active", 64'(seen), 64'd1);
    end
    @(posedge clk); #3;
    rst_ni = 1'b0;
    #1;
    chk("rst_async_outputs", {mst_w_valid_o, slv_w_ready_o, mst_w_last_o, err_o,
                              mst_w_data_o, mst_w_strb_o, mst_w_user_o}, 64'd0);
    chk("rst_async_cmd_ready", 64'(cmd_ready_o), 64'd1);
    expq.delete(); wq.delete(); obs.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    err_base = err_seen;
    repeat (6) begin @(posedge clk); #1; end
    chk("rst_no_stale_beats", 64'(obs.size()), 64'd0);
    issue(4, 2, 0, 8'h3C, 0);
    drain(100);
    chk("rst_after_beat", {obs[0].strb, obs[0].last, obs[0].pop}, {4'h3, 1'b1, 1'b1});
    chk("rst_after_count", 64'(obs.size()), 64'd1);
    chk("rst_after_err", 64'(err_seen - err_base), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
